n2_wb_arb: RTL and testbench
============================

N2_WB_ARB -- requirements
Module: n2_wb_arb

Interface
REQ-001 SHALL have parameter MU_FIFO_DEPTH, default 2: entries buffering MU results (power of two, >=2).
REQ-002 SHALL have parameter LSU_STARVE_MAX, default 4: consecutive LSU losses to MU before LSU is promoted.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 alu_v_i / alu_uid_i / alu_dst_i / alu_rst_i  in  1/8/regindex_bits/32  ALU result, no backpressure.
REQ-006 rf_we_mu_i / uid_mu_i / rf_dst_mu_i / alu_rst_mu_i  in  1/8/regindex_bits/32  mul/div result, no backpressure.
REQ-007 lsu_v_i / lsu_uid_i / lsu_dst_i / lsu_rst_i  in  1/8/regindex_bits/32  load result request.
REQ-008 lsu_ready_o  out  1  LSU result accepted this cycle.
REQ-009 mu_stall_o  out  1  issue stage SHALL NOT issue mul/div while high.
REQ-010 rf_we_o / rf_dst_o / rf_wdata_o  out  1/regindex_bits/32  registered register-file write port.
REQ-011 retire_v_o / uid_wb_o / wb_src_o  out  1/8/2  registered retire strobe, uid, source (wb_src_e).
REQ-012 wb_ovf_o  out  1  sticky MU FIFO overflow error.

Function
REQ-013 Each cycle SHALL grant at most one candidate: ALU > (MU head vs LSU per REQ-016).
REQ-014 MU result SHALL be pushed into FIFO; an empty FIFO SHALL fall through, so MU head is eligible in the push cycle.
REQ-015 Winner SHALL appear on outputs exactly 1 cycle after grant; non-grant cycles drive retire_v_o=0, rf_we_o=0.
REQ-016 LSU SHALL beat MU head only when the starve counter == LSU_STARVE_MAX; otherwise MU head wins.
REQ-017 Starve counter SHALL increment when LSU valid and MU wins, clear when LSU granted or LSU not valid, and not change when ALU wins.
REQ-018 lsu_ready_o SHALL be combinational, high only in LSU-grant cycles; LSU holds valid/uid/dst/data stable until ready.
REQ-019 Popping the FIFO SHALL occur only on MU grant; simultaneous push and pop SHALL keep count unchanged, including when full.
REQ-020 Push while full with no pop SHALL drop the entry and set wb_ovf_o until reset.
REQ-021 mu_stall_o SHALL be high when count >= MU_FIFO_DEPTH-1, registered-count based, covering 2-cycle mul in flight.
REQ-022 dst == 0 SHALL give retire_v_o=1, rf_we_o=0; rf_wdata_o SHALL still carry the data.
REQ-023 FIFO pointers SHALL wrap modulo MU_FIFO_DEPTH; count width SHALL be clog2(MU_FIFO_DEPTH)+1.
REQ-024 Order within MU SHALL be preserved; no ordering across sources is guaranteed (uid identifies the instruction).

Reset
REQ-025 On resetn low, asynchronously: rf_we_o=0, retire_v_o=0, rf_dst_o=0, rf_wdata_o=0, uid_wb_o=0, wb_src_o=WB_NONE, wb_ovf_o=0, FIFO empty, starve counter=0.
REQ-026 Reset mid-operation SHALL discard buffered MU results; lsu_ready_o SHALL be 0 during reset.
REQ-027 First grant SHALL be possible in the first clock after resetn deasserts.

Structure
REQ-028 NanoCore_pkg SHALL hold wb_src_e (WB_NONE=0, WB_ALU=1, WB_MU=2, WB_LSU=3) and the existing regindex_bits.
REQ-029 The MU buffer SHALL be a sub-module n2_wb_fifo (fall-through, count/full/empty outputs); arbitration and output registers stay in n2_wb_arb.

Verification
REQ-030 ALU-only: alu_v_i=1, dst=5, data=0x1234, uid=0x11 -> next cycle rf_we_o=1, rf_dst_o=5, wdata=0x1234, uid_wb_o=0x11, wb_src_o=WB_ALU.
REQ-031 ALU and MU same cycle (MU uid 0x22): ALU out at T+1, MU out at T+2. mu_stall_o high during T+1, low by T+3.
REQ-032 LSU held valid while MU pushes every cycle: LSU granted on the 5th cycle. Check the lsu_ready_o pulse and WB_LSU output, then the counter clears.
REQ-033 Fill FIFO (ALU valid blocks pops), push third MU -> wb_ovf_o=1 and stays 1. The first two MU uids retire in order once ALU idles.
REQ-034 dst=0 from ALU with data 0xFFFF_FFFF -> retire_v_o=1, rf_we_o=0.
REQ-035 Reset asserted with 2 FIFO entries and LSU waiting -> all outputs 0 immediately. After release no stale MU retire appears, and LSU is granted the first cycle.

Source files
------------

// File: rtl/NanoCore_pkg.sv
// Shared NanoCore types: register index width, writeback source tags and
// the result record carried through the writeback arbiter.
package NanoCore_pkg;

    localparam int regindex_bits = 5;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MU   = 2'd2,
        WB_LSU  = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic [7:0]               uid;
        logic [regindex_bits-1:0] dst;
        logic [31:0]              data;
    } wb_res_t;

endpackage

// File: rtl/n2_wb_fifo.sv
// Fall-through buffer for mul/div results. An empty FIFO presents the
// incoming push as its head in the same cycle so the arbiter can grant it
// without a bubble; a push and pop in the same cycle leave the count unchanged.
module n2_wb_fifo
    import NanoCore_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  wb_res_t       push_data,
    input  logic          pop,
    output wb_res_t       head,
    output logic          head_vld,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    wb_res_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          bypass;
    logic          do_wr;
    logic          do_rd;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    // Push consumed straight through to the arbiter: nothing is stored.
    assign bypass   = empty & push & pop;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_wr    = push & ~bypass & (~full | pop);
    assign do_rd    = pop & ~empty;
    assign drop     = push & full & ~pop;
    assign head_vld = ~empty | push;
    assign head     = empty ? push_data : mem[rd_ptr];

    // Pointer and occupancy state; pointers wrap naturally at power-of-two depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    // Entry storage; contents are qualified by the count, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/n2_wb_arb.sv
// Writeback arbiter: merges ALU, mul/div and load results onto a single
// register-file write port. ALU always wins; the buffered mul/div head beats
// the LSU unless the LSU has lost to it LSU_STARVE_MAX times in a row.
module n2_wb_arb
    import NanoCore_pkg::*;
#(
    parameter int MU_FIFO_DEPTH  = 2,
    parameter int LSU_STARVE_MAX = 4,
    parameter int DATA_W         = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     alu_v_i,
    input  logic [7:0]               alu_uid_i,
    input  logic [regindex_bits-1:0] alu_dst_i,
    input  logic [DATA_W-1:0]        alu_rst_i,
    input  logic                     rf_we_mu_i,
    input  logic [7:0]               uid_mu_i,
    input  logic [regindex_bits-1:0] rf_dst_mu_i,
    input  logic [DATA_W-1:0]        alu_rst_mu_i,
    input  logic                     lsu_v_i,
    input  logic [7:0]               lsu_uid_i,
    input  logic [regindex_bits-1:0] lsu_dst_i,
    input  logic [DATA_W-1:0]        lsu_rst_i,
    output logic                     lsu_ready_o,
    output logic                     mu_stall_o,
    output logic                     rf_we_o,
    output logic [regindex_bits-1:0] rf_dst_o,
    output logic [DATA_W-1:0]        rf_wdata_o,
    output logic                     retire_v_o,
    output logic [7:0]               uid_wb_o,
    output wb_src_e                  wb_src_o,
    output logic                     wb_ovf_o
);

    localparam int CW = $clog2(MU_FIFO_DEPTH) + 1;
    localparam int SW = $clog2(LSU_STARVE_MAX + 1);

    wb_res_t       mu_head_p0;
    logic          mu_head_vld_p0;
    logic [CW-1:0] mu_count;
    logic          mu_full;
    logic          mu_empty;
    logic          mu_drop;
    logic [SW-1:0] starve_q;
    logic          grant_alu_p0;
    logic          grant_mu_p0;
    logic          grant_lsu_p0;
    logic          grant_any_p0;
    wb_res_t       win_p0;
    wb_src_e       win_src_p0;

    // Saturating increment for the LSU starvation counter.
    function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] v);
        return (v == SW'(LSU_STARVE_MAX)) ? v : v + 1'b1;
    endfunction

    n2_wb_fifo #(.DEPTH(MU_FIFO_DEPTH)) u_mu_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rf_we_mu_i),
        .push_data ('{uid: uid_mu_i, dst: rf_dst_mu_i, data: alu_rst_mu_i}),
        .pop       (grant_mu_p0),
        .head      (mu_head_p0),
        .head_vld  (mu_head_vld_p0),
        .count     (mu_count),
        .full      (mu_full),
        .empty     (mu_empty),
        .drop      (mu_drop)
    );

    // ---- stage p0: grant selection and winner mux ----
    // Fixed ALU priority, then MU head unless the LSU has starved long enough.
    always_comb begin
        grant_alu_p0 = 1'b0;
        grant_mu_p0  = 1'b0;
        grant_lsu_p0 = 1'b0;
        if (alu_v_i) begin
            grant_alu_p0 = 1'b1;
        end else if (mu_head_vld_p0 && lsu_v_i) begin
            if (starve_q == SW'(LSU_STARVE_MAX)) grant_lsu_p0 = 1'b1;
            else                                 grant_mu_p0  = 1'b1;
        end else if (mu_head_vld_p0) begin
            grant_mu_p0 = 1'b1;
        end else if (lsu_v_i) begin
            grant_lsu_p0 = 1'b1;
        end
    end

    assign grant_any_p0 = grant_alu_p0 | grant_mu_p0 | grant_lsu_p0;

    // Route the granted source's fields; idle cycles carry zeros and WB_NONE.
    always_comb begin
        win_p0     = '0;
        win_src_p0 = WB_NONE;
        if (grant_alu_p0) begin
            win_p0     = '{uid: alu_uid_i, dst: alu_dst_i, data: alu_rst_i};
            win_src_p0 = WB_ALU;
        end else if (grant_mu_p0) begin
            win_p0     = mu_head_p0;
            win_src_p0 = WB_MU;
        end else if (grant_lsu_p0) begin
            win_p0     = '{uid: lsu_uid_i, dst: lsu_dst_i, data: lsu_rst_i};
            win_src_p0 = WB_LSU;
        end
    end

    // Reset gating keeps the handshake quiet while the arbiter is held in reset.
    assign lsu_ready_o = grant_lsu_p0 & resetn;
    // Registered count leaves room for a mul/div already in its 2-cycle flight.
    assign mu_stall_o  = (mu_count >= CW'(MU_FIFO_DEPTH - 1));

    // Starvation count: held while ALU owns the port, grows only when MU beats a waiting LSU.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= '0;
        end else if (!alu_v_i) begin
            if (lsu_v_i && grant_mu_p0) starve_q <= starve_inc(starve_q);
            else                        starve_q <= '0;
        end
    end

    // Sticky overflow flag for an MU result dropped against a full buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      wb_ovf_o <= 1'b0;
        else if (mu_drop) wb_ovf_o <= 1'b1;
    end

    // ---- stage p1: registered writeback port ----
    // Writes to r0 still retire but never assert the register-file write enable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            retire_v_o <= 1'b0;
            rf_we_o    <= 1'b0;
            rf_dst_o   <= '0;
            rf_wdata_o <= '0;
            uid_wb_o   <= '0;
            wb_src_o   <= WB_NONE;
        end else begin
            retire_v_o <= grant_any_p0;
            rf_we_o    <= grant_any_p0 && (win_p0.dst != '0);
            rf_dst_o   <= win_p0.dst;
            rf_wdata_o <= win_p0.data;
            uid_wb_o   <= win_p0.uid;
            wb_src_o   <= win_src_p0;
        end
    end

endmodule

// File: tb/tb_n2_wb_arb.sv
// Directed bench for n2_wb_arb: expected retirements are queued as stimulus
// is driven and compared against the writeback port one cycle later.
module tb_n2_wb_arb;
    import NanoCore_pkg::*;

    typedef struct {
        logic [7:0]  uid;
        logic [4:0]  dst;
        logic [31:0] data;
        wb_src_e     src;
        logic        we;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        alu_v_i, rf_we_mu_i, lsu_v_i;
    logic [7:0]  alu_uid_i, uid_mu_i, lsu_uid_i;
    logic [4:0]  alu_dst_i, rf_dst_mu_i, lsu_dst_i;
    logic [31:0] alu_rst_i, alu_rst_mu_i, lsu_rst_i;
    logic        lsu_ready_o, mu_stall_o, rf_we_o, retire_v_o, wb_ovf_o;
    logic [4:0]  rf_dst_o;
    logic [31:0] rf_wdata_o;
    logic [7:0]  uid_wb_o;
    wb_src_e     wb_src_o;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    n2_wb_arb #(.MU_FIFO_DEPTH(2), .LSU_STARVE_MAX(4), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .alu_v_i      (alu_v_i),
        .alu_uid_i    (alu_uid_i),
        .alu_dst_i    (alu_dst_i),
        .alu_rst_i    (alu_rst_i),
        .rf_we_mu_i   (rf_we_mu_i),
        .uid_mu_i     (uid_mu_i),
        .rf_dst_mu_i  (rf_dst_mu_i),
        .alu_rst_mu_i (alu_rst_mu_i),
        .lsu_v_i      (lsu_v_i),
        .lsu_uid_i    (lsu_uid_i),
        .lsu_dst_i    (lsu_dst_i),
        .lsu_rst_i    (lsu_rst_i),
        .lsu_ready_o  (lsu_ready_o),
        .mu_stall_o   (mu_stall_o),
        .rf_we_o      (rf_we_o),
        .rf_dst_o     (rf_dst_o),
        .rf_wdata_o   (rf_wdata_o),
        .retire_v_o   (retire_v_o),
        .uid_wb_o     (uid_wb_o),
        .wb_src_o     (wb_src_o),
        .wb_ovf_o     (wb_ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] uid, input logic [4:0] dst,
                            input logic [31:0] data, input wb_src_e src);
        exp_t e;
        e.uid = uid; e.dst = dst; e.data = data; e.src = src;
        e.we  = (dst != 5'd0);
        exp_q.push_back(e);
    endtask

    task automatic check_retire(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_retire"}, 64'(retire_v_o), 64'd1);
            chk({tag, "_we"},     64'(rf_we_o),    64'(e.we));
            chk({tag, "_dst"},    64'(rf_dst_o),   64'(e.dst));
            chk({tag, "_data"},   64'(rf_wdata_o), 64'(e.data));
            chk({tag, "_uid"},    64'(uid_wb_o),   64'(e.uid));
            chk({tag, "_src"},    64'(wb_src_o),   64'(e.src));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_retire"}, 64'(retire_v_o), 64'd0);
        chk({tag, "_we"},     64'(rf_we_o),    64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_retire"}, 64'(retire_v_o),  64'd0);
        chk({tag, "_we"},     64'(rf_we_o),     64'd0);
        chk({tag, "_dst"},    64'(rf_dst_o),    64'd0);
        chk({tag, "_data"},   64'(rf_wdata_o),  64'd0);
        chk({tag, "_uid"},    64'(uid_wb_o),    64'd0);
        chk({tag, "_src"},    64'(wb_src_o),    64'(WB_NONE));
        chk({tag, "_ovf"},    64'(wb_ovf_o),    64'd0);
        chk({tag, "_ready"},  64'(lsu_ready_o), 64'd0);
        chk({tag, "_stall"},  64'(mu_stall_o),  64'd0);
    endtask

    task automatic drive_alu(input logic v, input logic [7:0] uid,
                             input logic [4:0] dst, input logic [31:0] data);
        alu_v_i = v; alu_uid_i = uid; alu_dst_i = dst; alu_rst_i = data;
    endtask

    task automatic drive_mu(input logic v, input logic [7:0] uid,
                            input logic [4:0] dst, input logic [31:0] data);
        rf_we_mu_i = v; uid_mu_i = uid; rf_dst_mu_i = dst; alu_rst_mu_i = data;
    endtask

    task automatic drive_lsu(input logic v, input logic [7:0] uid,
                             input logic [4:0] dst, input logic [31:0] data);
        lsu_v_i = v; lsu_uid_i = uid; lsu_dst_i = dst; lsu_rst_i = data;
    endtask

    initial begin
        resetn = 1'b0;
        drive_alu(1'b0, 8'h0, 5'd0, 32'h0);
        drive_mu (1'b0, 8'h0, 5'd0, 32'h0);
        drive_lsu(1'b0, 8'h0, 5'd0, 32'h0);

        // Reset state
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        // ALU-only result retires one cycle later
        drive_alu(1'b1, 8'h11, 5'd5, 32'h0000_1234);
        push_exp(8'h11, 5'd5, 32'h0000_1234, WB_ALU);
        tick();
        check_retire("alu_only");
        drive_alu(1'b0, 8'h0, 5'd0, 32'h0);
        tick();
        check_idle("alu_only_idle");

        // ALU and MU collide: ALU first, buffered MU next, stall while buffered
        drive_alu(1'b1, 8'h33, 5'd3, 32'h0000_3333);
        drive_mu (1'b1, 8'h22, 5'd7, 32'h0000_BEEF);
        push_exp(8'h33, 5'd3, 32'h0000_3333, WB_ALU);
        push_exp(8'h22, 5'd7, 32'h0000_BEEF, WB_MU);
        tick();
        check_retire("coll_alu");
        chk("coll_stall_t1", 64'(mu_stall_o), 64'd1);
        drive_alu(1'b0, 8'h0, 5'd0, 32'h0);
        drive_mu (1'b0, 8'h0, 5'd0, 32'h0);
        tick();
        check_retire("coll_mu");
        tick();
        check_idle("coll_idle");
        chk("coll_stall_t3", 64'(mu_stall_o), 64'd0);

        // Write to r0 retires without a register-file write
        drive_alu(1'b1, 8'h44, 5'd0, 32'hFFFF_FFFF);
        push_exp(8'h44, 5'd0, 32'hFFFF_FFFF, WB_ALU);
        tick();
        check_retire("dst0");
        drive_alu(1'b0, 8'h0, 5'd0, 32'h0);

        // LSU waits behind a stream of MU pushes, wins on the fifth cycle
        drive_lsu(1'b1, 8'h55, 5'd9, 32'h0000_CAFE);
        for (int i = 0; i < 5; i++) begin
            drive_mu(1'b1, 8'h60 + 8'(i), 5'd1, 32'(i));
            #1;
            chk($sformatf("starve_ready_%0d", i), 64'(lsu_ready_o), (i == 4) ? 64'd1 : 64'd0);
            if (i == 4) push_exp(8'h55, 5'd9, 32'h0000_CAFE, WB_LSU);
            else        push_exp(8'h60 + 8'(i), 5'd1, 32'(i), WB_MU);
            tick();
            check_retire($sformatf("starve_%0d", i));
        end
        // Counter must have cleared: a fresh LSU request loses to the MU head again
        drive_mu (1'b0, 8'h0, 5'd0, 32'h0);
        drive_lsu(1'b1, 8'h56, 5'd10, 32'h0000_D00D);
        #1;
        chk("starve_clear_ready", 64'(lsu_ready_o), 64'd0);
        push_exp(8'h64, 5'd1, 32'd4, WB_MU);
        tick();
        check_retire("starve_clear_mu");
        chk("starve_lsu2_ready", 64'(lsu_ready_o), 64'd1);
        push_exp(8'h56, 5'd10, 32'h0000_D00D, WB_LSU);
        tick();
        check_retire("starve_lsu2");
        drive_lsu(1'b0, 8'h0, 5'd0, 32'h0);
        tick();
        check_idle("starve_idle");

        // Fill the MU buffer behind ALU traffic and overflow it
        for (int k = 0; k < 3; k++) begin
            drive_alu(1'b1, 8'h81 + 8'(k), 5'd2, 32'h100 + 32'(k));
            drive_mu (1'b1, 8'h91 + 8'(k), 5'd4, 32'h900 + 32'(k));
            push_exp(8'h81 + 8'(k), 5'd2, 32'h100 + 32'(k), WB_ALU);
            tick();
            check_retire($sformatf("ovf_alu_%0d", k));
            if (k == 1) begin
                chk("ovf_full_stall", 64'(mu_stall_o), 64'd1);
                chk("ovf_before", 64'(wb_ovf_o), 64'd0);
            end
        end
        chk("ovf_set", 64'(wb_ovf_o), 64'd1);
        drive_alu(1'b0, 8'h0, 5'd0, 32'h0);
        drive_mu (1'b0, 8'h0, 5'd0, 32'h0);
        push_exp(8'h91, 5'd4, 32'h900, WB_MU);
        push_exp(8'h92, 5'd4, 32'h901, WB_MU);
        tick();
        check_retire("ovf_mu0");
        tick();
        check_retire("ovf_mu1");
        tick();
        check_idle("ovf_no_third");
        chk("ovf_sticky", 64'(wb_ovf_o), 64'd1);

        // Reset mid-operation with two buffered MU results and LSU waiting
        drive_lsu(1'b1, 8'hB1, 5'd6, 32'h0000_B1B1);
        for (int k = 0; k < 2; k++) begin
            drive_alu(1'b1, 8'hA8 + 8'(k), 5'd8, 32'hA80 + 32'(k));
            drive_mu (1'b1, 8'hA1 + 8'(k), 5'd3, 32'hA10 + 32'(k));
            push_exp(8'hA8 + 8'(k), 5'd8, 32'hA80 + 32'(k), WB_ALU);
            tick();
            check_retire($sformatf("rst_fill_%0d", k));
        end
        chk("rst_fill_stall", 64'(mu_stall_o), 64'd1);
        drive_alu(1'b0, 8'h0, 5'd0, 32'h0);
        drive_mu (1'b0, 8'h0, 5'd0, 32'h0);
        resetn = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clk); #1;
        check_all_zero("rst_held");
        resetn = 1'b1;
        #1;
        chk("rst_first_ready", 64'(lsu_ready_o), 64'd1);
        push_exp(8'hB1, 5'd6, 32'h0000_B1B1, WB_LSU);
        tick();
        check_retire("rst_lsu");
        drive_lsu(1'b0, 8'h0, 5'd0, 32'h0);
        tick();
        check_idle("rst_no_stale0");
        tick();
        check_idle("rst_no_stale1");
        chk("rst_stall_low", 64'(mu_stall_o), 64'd0);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
